ahb_uart_tx: RTL

AHB-Lite slave that hangs off the AHB bus matrix as a slave port beside the data cache and GPIO. The core writes bytes into a small transmit FIFO. A TX state machine serialises them as 8N1 frames on a single TXD pin, at a baud rate set by a programmable divider. Zero-wait-state slave with status readback, giving the core a debug and console output path.

---
 rtl/ahb_uart_tx_if.sv | 27 ++
 rtl/ahb_uart_tx.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_uart_tx_if.sv
// AHB-Lite bus bundle between the bus matrix (master side) and the UART TX slave.
// Master drives the address/control/write data; the slave returns hrdata, hresp
// and hready.
interface ahb_uart_tx_if;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hwrite;
    logic        hsel;
    logic        hmastlock;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic        hresp;
    logic        hready;

    modport master (
        output haddr, hwdata, hwrite, hsel, hmastlock, htrans, hsize, hburst, hprot,
        input  hrdata, hresp, hready
    );

    modport slave (
        input  haddr, hwdata, hwrite, hsel, hmastlock, htrans, hsize, hburst, hprot,
        output hrdata, hresp, hready
    );
endinterface

// File: rtl/ahb_uart_tx.sv
// AHB-Lite UART transmitter: zero-wait-state slave feeding a small byte FIFO that
// a TX state machine serialises as 8N1 frames on txd.
// Ports:
//   CLK  - system clock, rising edge
//   RST  - synchronous active-high reset
//   ahb  - AHB-Lite slave bundle (hrdata combinational in the data phase,
//          hresp tied OKAY, hready tied 1)
//   txd  - serial output, idle high
//   irq  - level, high when FIFO empty and transmitter idle
// Registers (haddr[3:2]): 0 TXDATA, 1 STATUS, 2 BAUDDIV, 3 reserved.
module ahb_uart_tx #(
    parameter logic [31:0] START_ADDR   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter logic [15:0] BAUD_DIV_RST = 16'd867
) (
    input  logic         CLK,
    input  logic         RST,
    ahb_uart_tx_if.slave ahb,
    output logic         txd,
    output logic         irq
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    localparam logic [1:0] ADDR_TXDATA  = 2'd0;
    localparam logic [1:0] ADDR_STATUS  = 2'd1;
    localparam logic [1:0] ADDR_BAUDDIV = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    // Bus pipeline registers
    logic             r_dp_valid;
    logic             r_dp_write;
    logic [1:0]       r_dp_addr;

    // FIFO and control registers
    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             r_ovf;
    logic [15:0]      r_baud_div;

    // Transmitter registers
    state_t           r_state;
    logic [15:0]      r_baud_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic             r_txd;
    logic             r_irq;

    // Combinational signals
    logic             w_hready;
    logic             w_addr_ph;
    logic             w_wr;
    logic             w_push_req;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic             w_busy;
    logic             w_ovf_set;
    logic             w_tick;
    logic [CNT_W-1:0] w_count_nxt;
    logic [31:0]      w_status;
    logic [31:0]      w_hrdata;
    state_t           w_state_nxt;
    logic [15:0]      w_cnt_nxt;
    logic [2:0]       w_bit_nxt;
    logic [7:0]       w_shift_nxt;
    logic             w_txd_nxt;
    logic             w_irq_nxt;
    logic             w_unused;

    // Width, size, burst, protection and the upper address bits do not affect decode
    assign w_unused = &{1'b0, ahb.haddr[31:4], ahb.haddr[1:0], ahb.hwdata[31:16],
                        ahb.hmastlock, ahb.hsize, ahb.hburst, ahb.hprot,
                        ahb.htrans[0], START_ADDR};

    assign w_hready   = 1'b1;
    assign ahb.hready = w_hready;
    assign ahb.hresp  = 1'b0;
    assign ahb.hrdata = w_hrdata;
    assign txd        = r_txd;
    assign irq        = r_irq;

    assign w_addr_ph  = ahb.hsel & ahb.htrans[1] & w_hready;
    assign w_wr       = r_dp_valid & r_dp_write;
    assign w_push_req = w_wr & (r_dp_addr == ADDR_TXDATA);
    assign w_full     = (r_count == FULL_CNT);
    assign w_empty    = (r_count == '0);
    assign w_busy     = (r_state != ST_IDLE);
    // A push into a full FIFO only lands if the transmitter frees a slot this cycle
    assign w_push     = w_push_req & (~w_full | w_pop);
    assign w_ovf_set  = w_push_req & w_full & ~w_pop;
    assign w_tick     = (r_baud_cnt == '0);
    assign w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

    assign w_status = {20'd0, 4'(r_count), 4'd0, r_ovf, w_busy, w_empty, w_full};

    // Read data mux, only live during a read data phase
    always_comb begin
        w_hrdata = '0;
        if (r_dp_valid && !r_dp_write) begin
            case (r_dp_addr)
                ADDR_STATUS:  w_hrdata = w_status;
                ADDR_BAUDDIV: w_hrdata = {16'd0, r_baud_div};
                default:      w_hrdata = '0;
            endcase
        end
    end

    // Address-phase capture
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_dp_valid <= 1'b0;
            r_dp_write <= 1'b0;
            r_dp_addr  <= 2'd0;
        end else begin
            r_dp_valid <= w_addr_ph;
            r_dp_write <= ahb.hwrite;
            r_dp_addr  <= ahb.haddr[3:2];
        end
    end

    // FIFO storage; contents need no reset since count gates every read
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wptr] <= ahb.hwdata[7:0];
        end
    end

    // FIFO pointers, overflow flag and baud divisor
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_ovf      <= 1'b0;
            r_baud_div <= BAUD_DIV_RST;
        end else begin
            r_count <= w_count_nxt;
            if (w_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (w_wr && (r_dp_addr == ADDR_STATUS) && ahb.hwdata[3]) begin
                r_ovf <= 1'b0;
            end
            if (w_wr && (r_dp_addr == ADDR_BAUDDIV)) begin
                r_baud_div <= ahb.hwdata[15:0];
            end
        end
    end

    // TX state register
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // TX next state, FIFO pop and bit-timing datapath
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_cnt_nxt   = r_baud_cnt;
        w_bit_nxt   = r_bit_idx;
        w_shift_nxt = r_shift;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = r_mem[r_rptr];
                    w_cnt_nxt   = r_baud_div;
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (w_tick) begin
                    w_cnt_nxt   = r_baud_div;
                    w_bit_nxt   = 3'd0;
                    w_state_nxt = ST_DATA;
                end else begin
                    w_cnt_nxt = r_baud_cnt - 16'd1;
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    w_cnt_nxt = r_baud_div;
                    w_bit_nxt = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = ST_STOP;
                    end
                end else begin
                    w_cnt_nxt = r_baud_cnt - 16'd1;
                end
            end
            ST_STOP: begin
                if (w_tick) begin
                    w_cnt_nxt = r_baud_div;
                    // Chain straight into the next frame when data is waiting
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_shift_nxt = r_mem[r_rptr];
                        w_state_nxt = ST_START;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_baud_cnt - 16'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // TX outputs, computed from the next state so the registered pins line up with it
    always_comb begin
        w_txd_nxt = 1'b1;
        case (w_state_nxt)
            ST_START: w_txd_nxt = 1'b0;
            ST_DATA:  w_txd_nxt = w_shift_nxt[w_bit_nxt];
            default:  w_txd_nxt = 1'b1;
        endcase
        w_irq_nxt = (w_count_nxt == '0) && (w_state_nxt == ST_IDLE);
    end

    // TX datapath and output registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_txd      <= 1'b1;
            r_irq      <= 1'b1;
        end else begin
            r_baud_cnt <= w_cnt_nxt;
            r_bit_idx  <= w_bit_nxt;
            r_shift    <= w_shift_nxt;
            r_txd      <= w_txd_nxt;
            r_irq      <= w_irq_nxt;
        end
    end

endmodule
